// File: rtl/ibex_sleep_ctrl_pkg.sv
// ibex_sleep_ctrl_pkg: shared types for the WFI sleep controller and the core clock gate
package ibex_sleep_ctrl_pkg;

    // Multi-bit busy indication; On and Off differ in every bit so no single
    // flipped bit can turn one into the other.
    typedef enum logic [3:0] {
        IbexMuBiOn  = 4'b0101,
        IbexMuBiOff = 4'b1010
    } ibex_mubi_t;

    // Every pair of codes is at least Hamming distance 3 apart, so any single
    // or double bit upset lands on a value that is not a legal state.
    typedef enum logic [4:0] {
        SleepRun   = 5'b10101,
        SleepDrain = 5'b10010,
        SleepSleep = 5'b01100,
        SleepWake  = 5'b01011
    } sleep_ctrl_state_e;

endpackage

// File: rtl/ibex_sleep_ctrl.sv
// ibex_sleep_ctrl: WFI sequencer driving the core-busy indication to the main clock gate
//   clk_i/rst_i       ungated clock, synchronous active-high reset
//   wfi_req_i         WFI retired pulse from the controller
//   fetch_busy_i/lsu_busy_i  outstanding traffic that must drain before sleeping
//   debug_req_i/irq_pending_i/irq_nm_i  wake events
//   core_busy_o       mubi busy to the clock gate, sleeping_o, wfi_done_o pulse
//   sleep_cycles_o    saturating count of SLEEP cycles, alert_o illegal state (secure only)
module ibex_sleep_ctrl
    import ibex_sleep_ctrl_pkg::*;
#(
    parameter bit          SecureIbex = 1'b0,
    parameter int unsigned WakeDelay  = 2,
    parameter int unsigned CntWidth   = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wfi_req_i,
    input  logic                          fetch_busy_i,
    input  logic                          lsu_busy_i,
    input  logic                          debug_req_i,
    input  logic                          irq_pending_i,
    input  logic                          irq_nm_i,
    output logic [$bits(ibex_mubi_t)-1:0] core_busy_o,
    output logic                          sleeping_o,
    output logic                          wfi_done_o,
    output logic [CntWidth-1:0]           sleep_cycles_o,
    output logic                          alert_o
);

    localparam int unsigned DlyW = (WakeDelay > 1) ? $clog2(WakeDelay + 1) : 1;

    sleep_ctrl_state_e state;
    ibex_mubi_t        core_busy_q;
    logic              sleeping_q;
    logic              done_q;
    logic              alert_q;
    logic [CntWidth-1:0] cnt_q;
    logic [DlyW-1:0]   dly_q;
    logic              wake;

    assign wake = debug_req_i | irq_pending_i | irq_nm_i;

    // Busy/sleeping are updated together with the state transition so they
    // always reflect the state register without a decode stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= SleepRun;
            core_busy_q <= IbexMuBiOn;
            sleeping_q  <= 1'b0;
            done_q      <= 1'b0;
            alert_q     <= 1'b0;
            cnt_q       <= '0;
            dly_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == SleepSleep && cnt_q != '1) cnt_q <= cnt_q + CntWidth'(1);
            case (state)
                SleepRun: begin
                    if (wfi_req_i) begin
                        if (wake) done_q <= 1'b1;
                        else      state  <= SleepDrain;
                    end
                end
                SleepDrain: begin
                    if (wake) begin
                        state  <= SleepRun;
                        done_q <= 1'b1;
                    end else if (!fetch_busy_i && !lsu_busy_i) begin
                        state       <= SleepSleep;
                        core_busy_q <= IbexMuBiOff;
                        sleeping_q  <= 1'b1;
                    end
                end
                SleepSleep: begin
                    if (wake) begin
                        core_busy_q <= IbexMuBiOn;
                        sleeping_q  <= 1'b0;
                        if (WakeDelay == 0) begin
                            state  <= SleepRun;
                            done_q <= 1'b1;
                        end else begin
                            state <= SleepWake;
                            dly_q <= DlyW'(WakeDelay);
                        end
                    end
                end
                SleepWake: begin
                    if (dly_q == DlyW'(1)) begin
                        state  <= SleepRun;
                        done_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q - DlyW'(1);
                    end
                end
                // Fail safe: an unknown state keeps the clock running.
                default: begin
                    state       <= SleepRun;
                    core_busy_q <= IbexMuBiOn;
                    sleeping_q  <= 1'b0;
                    alert_q     <= SecureIbex;
                end
            endcase
        end
    end

    assign core_busy_o    = core_busy_q;
    assign sleeping_o     = sleeping_q;
    assign wfi_done_o     = done_q;
    assign sleep_cycles_o = cnt_q;
    assign alert_o        = alert_q;

endmodule

// File: tb/tb_ibex_sleep_ctrl.sv
// tb_ibex_sleep_ctrl: randomized and directed checks of two sleep controller configurations
module tb_ibex_sleep_ctrl;
    import ibex_sleep_ctrl_pkg::*;

    localparam int M_RUN = 0, M_DRAIN = 1, M_SLEEP = 2, M_WAKE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, wfi, fb, lb, dbg, irq, nmi;
    logic [3:0]  busy_a, busy_b;
    logic        slp_a, slp_b, done_a, done_b, alert_a, alert_b;
    logic [31:0] cyc_a;
    logic [3:0]  cyc_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance a: secure, WakeDelay 2, 32-bit counter. Instance b: plain, WakeDelay 0, 4-bit counter.
    ibex_sleep_ctrl #(.SecureIbex(1'b1), .WakeDelay(2), .CntWidth(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .wfi_req_i(wfi), .fetch_busy_i(fb), .lsu_busy_i(lb),
        .debug_req_i(dbg), .irq_pending_i(irq), .irq_nm_i(nmi),
        .core_busy_o(busy_a), .sleeping_o(slp_a), .wfi_done_o(done_a),
        .sleep_cycles_o(cyc_a), .alert_o(alert_a)
    );

    ibex_sleep_ctrl #(.SecureIbex(1'b0), .WakeDelay(0), .CntWidth(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .wfi_req_i(wfi), .fetch_busy_i(fb), .lsu_busy_i(lb),
        .debug_req_i(dbg), .irq_pending_i(irq), .irq_nm_i(nmi),
        .core_busy_o(busy_b), .sleeping_o(slp_b), .wfi_done_o(done_b),
        .sleep_cycles_o(cyc_b), .alert_o(alert_b)
    );

    // Reference model: phase per instance, remaining wake cycles, unsaturated sleep total.
    int     ph[2];
    int     rem[2];
    longint tot[2];
    bit     mdone[2];
    bit     malert[2];
    int     wd[2] = '{2, 0};
    longint mx[2] = '{64'hFFFF_FFFF, 64'd15};

    task automatic model_step(input bit illegal_a);
        bit wk;
        wk = dbg | irq | nmi;
        for (int i = 0; i < 2; i++) begin
            mdone[i] = 1'b0;
            if (rst) begin
                ph[i] = M_RUN; rem[i] = 0; tot[i] = 0; malert[i] = 1'b0;
            end else if (i == 0 && illegal_a) begin
                ph[i] = M_RUN; malert[i] = 1'b1;
            end else begin
                if (ph[i] == M_SLEEP) tot[i]++;
                if (ph[i] == M_RUN) begin
                    if (wfi && wk) mdone[i] = 1'b1;
                    else if (wfi) ph[i] = M_DRAIN;
                end else if (ph[i] == M_DRAIN) begin
                    if (wk) begin ph[i] = M_RUN; mdone[i] = 1'b1; end
                    else if (!fb && !lb) ph[i] = M_SLEEP;
                end else if (ph[i] == M_SLEEP) begin
                    if (wk && wd[i] == 0) begin ph[i] = M_RUN; mdone[i] = 1'b1; end
                    else if (wk) begin ph[i] = M_WAKE; rem[i] = wd[i]; end
                end else begin
                    rem[i]--;
                    if (rem[i] == 0) begin ph[i] = M_RUN; mdone[i] = 1'b1; end
                end
            end
        end
    endtask

    task automatic tick(input bit illegal_a);
        @(posedge clk);
        model_step(illegal_a);
        @(negedge clk);
    endtask

    function automatic logic [3:0] exp_busy(input int i);
        return (ph[i] == M_SLEEP) ? IbexMuBiOff : IbexMuBiOn;
    endfunction

    function automatic longint exp_cyc(input int i);
        return (tot[i] > mx[i]) ? mx[i] : tot[i];
    endfunction

    task automatic idle_inputs();
        wfi = 0; fb = 0; lb = 0; dbg = 0; irq = 0; nmi = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(0); tick(0); rst = 0;
        n_tests++; if (busy_a !== IbexMuBiOn) begin n_fail++; $display("FAIL reset_busy_a got %h want %h", busy_a, IbexMuBiOn); end
        n_tests++; if (busy_b !== IbexMuBiOn) begin n_fail++; $display("FAIL reset_busy_b got %h want %h", busy_b, IbexMuBiOn); end
        n_tests++; if ({slp_a, done_a, alert_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_a got %b want 000", {slp_a, done_a, alert_a}); end
        n_tests++; if ({slp_b, done_b, alert_b} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_b got %b want 000", {slp_b, done_b, alert_b}); end
        n_tests++; if (cyc_a !== 32'd0 || cyc_b !== 4'd0) begin n_fail++; $display("FAIL reset_cycles got %0d/%0d want 0/0", cyc_a, cyc_b); end
    endtask

    task automatic test_sleep_wake();
        idle_inputs();
        wfi = 1; tick(0); wfi = 0;
        n_tests++; if (busy_a !== IbexMuBiOn) begin n_fail++; $display("FAIL drain_busy got %h want %h", busy_a, IbexMuBiOn); end
        tick(0);
        n_tests++; if (busy_a !== IbexMuBiOff || slp_a !== 1'b1) begin n_fail++; $display("FAIL sleep_entry got busy %h slp %b want %h 1", busy_a, slp_a, IbexMuBiOff); end
        for (int k = 0; k < 9; k++) tick(0);
        irq = 1; tick(0);
        n_tests++; if (cyc_a !== 32'd10) begin n_fail++; $display("FAIL sleep_count got %0d want 10", cyc_a); end
        n_tests++; if (busy_a !== IbexMuBiOn || slp_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL wake_first got busy %h slp %b done %b want %h 0 0", busy_a, slp_a, done_a, IbexMuBiOn); end
        n_tests++; if (done_b !== 1'b1 || busy_b !== IbexMuBiOn) begin n_fail++; $display("FAIL wake_nodelay_b got done %b busy %h want 1 %h", done_b, busy_b, IbexMuBiOn); end
        irq = 0; tick(0);
        n_tests++; if (done_a !== 1'b0 || busy_a !== IbexMuBiOn) begin n_fail++; $display("FAIL wake_hold got done %b busy %h want 0 %h", done_a, busy_a, IbexMuBiOn); end
        tick(0);
        n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL wake_done got %b want 1", done_a); end
        tick(0);
        n_tests++; if (done_a !== 1'b0 || cyc_a !== 32'd10) begin n_fail++; $display("FAIL after_wake got done %b cyc %0d want 0 10", done_a, cyc_a); end
    endtask

    task automatic test_wfi_with_wake();
        idle_inputs();
        nmi = 1; wfi = 1; tick(0); wfi = 0;
        n_tests++; if (done_a !== 1'b1 || done_b !== 1'b1) begin n_fail++; $display("FAIL wfi_wake_done got %b/%b want 1/1", done_a, done_b); end
        n_tests++; if (busy_a !== IbexMuBiOn || slp_a !== 1'b0) begin n_fail++; $display("FAIL wfi_wake_busy got %h slp %b want %h 0", busy_a, slp_a, IbexMuBiOn); end
        tick(0);
        n_tests++; if (done_a !== 1'b0 || busy_a !== IbexMuBiOn) begin n_fail++; $display("FAIL wfi_wake_after got done %b busy %h want 0 %h", done_a, busy_a, IbexMuBiOn); end
        nmi = 0;
    endtask

    task automatic test_drain();
        idle_inputs();
        lb = 1; wfi = 1; tick(0); wfi = 0;
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (busy_a !== IbexMuBiOn) begin n_fail++; $display("FAIL drain_hold cycle %0d got %h want %h", k, busy_a, IbexMuBiOn); end
            tick(0);
        end
        lb = 0; tick(0);
        n_tests++; if (busy_a !== IbexMuBiOff || busy_b !== IbexMuBiOff) begin n_fail++; $display("FAIL drain_release got %h/%h want %h", busy_a, busy_b, IbexMuBiOff); end
        irq = 1; tick(0); tick(0); tick(0); irq = 0; tick(0);
        fb = 1; wfi = 1; tick(0); wfi = 0;
        dbg = 1; tick(0); dbg = 0;
        n_tests++; if (done_a !== 1'b1 || busy_a !== IbexMuBiOn || slp_a !== 1'b0) begin n_fail++; $display("FAIL drain_debug got done %b busy %h slp %b want 1 %h 0", done_a, busy_a, slp_a, IbexMuBiOn); end
        tick(0);
        n_tests++; if (busy_a !== IbexMuBiOn || done_a !== 1'b0) begin n_fail++; $display("FAIL drain_debug_after got busy %h done %b want %h 0", busy_a, done_a, IbexMuBiOn); end
        fb = 0;
    endtask

    task automatic test_saturation();
        idle_inputs();
        rst = 1; tick(0); rst = 0;
        wfi = 1; tick(0); wfi = 0; tick(0);
        for (int k = 0; k < 20; k++) tick(0);
        n_tests++; if (cyc_b !== 4'd15) begin n_fail++; $display("FAIL saturate_b got %0d want 15", cyc_b); end
        n_tests++; if (cyc_a !== 32'd20) begin n_fail++; $display("FAIL count_a got %0d want 20", cyc_a); end
        tick(0);
        n_tests++; if (cyc_b !== 4'd15 || slp_b !== 1'b1) begin n_fail++; $display("FAIL saturate_hold got %0d slp %b want 15 1", cyc_b, slp_b); end
    endtask

    task automatic test_reset_in_sleep();
        rst = 1; tick(0); rst = 0;
        n_tests++; if (busy_a !== IbexMuBiOn || busy_b !== IbexMuBiOn) begin n_fail++; $display("FAIL rst_sleep_busy got %h/%h want %h", busy_a, busy_b, IbexMuBiOn); end
        n_tests++; if (cyc_a !== 32'd0 || cyc_b !== 4'd0 || done_a !== 1'b0 || slp_a !== 1'b0) begin n_fail++; $display("FAIL rst_sleep_state got cyc %0d/%0d done %b slp %b want 0/0 0 0", cyc_a, cyc_b, done_a, slp_a); end
    endtask

    task automatic test_random();
        logic [3:0]  ab[2];
        logic        as[2], ad[2], aa[2];
        longint      ac[2];
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            wfi = ($urandom_range(0, 5) == 0);
            fb  = ($urandom_range(0, 2) == 0);
            lb  = ($urandom_range(0, 2) == 0);
            dbg = ($urandom_range(0, 19) == 0);
            irq = ($urandom_range(0, 19) == 0);
            nmi = ($urandom_range(0, 29) == 0);
            tick(0);
            ab = '{busy_a, busy_b}; as = '{slp_a, slp_b}; ad = '{done_a, done_b};
            aa = '{alert_a, alert_b}; ac = '{longint'(cyc_a), longint'(cyc_b)};
            for (int i = 0; i < 2; i++) begin
                n_tests++; if (ab[i] !== exp_busy(i)) begin n_fail++; $display("FAIL rnd_busy inst %0d cycle %0d got %h want %h", i, n, ab[i], exp_busy(i)); end
                n_tests++; if (as[i] !== (ph[i] == M_SLEEP)) begin n_fail++; $display("FAIL rnd_sleeping inst %0d cycle %0d got %b want %b", i, n, as[i], ph[i] == M_SLEEP); end
                n_tests++; if (ad[i] !== mdone[i]) begin n_fail++; $display("FAIL rnd_done inst %0d cycle %0d got %b want %b", i, n, ad[i], mdone[i]); end
                n_tests++; if (ac[i] !== exp_cyc(i)) begin n_fail++; $display("FAIL rnd_cycles inst %0d cycle %0d got %0d want %0d", i, n, ac[i], exp_cyc(i)); end
                n_tests++; if (aa[i] !== malert[i]) begin n_fail++; $display("FAIL rnd_alert inst %0d cycle %0d got %b want %b", i, n, aa[i], malert[i]); end
            end
        end
        rst = 0;
    endtask

    task automatic test_alert();
        idle_inputs();
        rst = 1; tick(0); rst = 0;
        wfi = 1; tick(0); wfi = 0; tick(0);
        force dut_a.state = sleep_ctrl_state_e'(5'b11111);
        tick(1);
        release dut_a.state;
        n_tests++; if (alert_a !== 1'b1) begin n_fail++; $display("FAIL alert_set got %b want 1", alert_a); end
        n_tests++; if (busy_a !== IbexMuBiOn || slp_a !== 1'b0) begin n_fail++; $display("FAIL alert_failsafe got busy %h slp %b want %h 0", busy_a, slp_a, IbexMuBiOn); end
        n_tests++; if (alert_b !== 1'b0 || busy_b !== IbexMuBiOff) begin n_fail++; $display("FAIL alert_other got alert %b busy %h want 0 %h", alert_b, busy_b, IbexMuBiOff); end
        tick(1);
        n_tests++; if (dut_a.state !== SleepRun) begin n_fail++; $display("FAIL alert_state got %b want %b", dut_a.state, SleepRun); end
        wfi = 1; tick(0); wfi = 0; tick(0);
        n_tests++; if (busy_a !== IbexMuBiOff || alert_a !== 1'b1) begin n_fail++; $display("FAIL alert_sticky got busy %h alert %b want %h 1", busy_a, alert_a, IbexMuBiOff); end
        n_tests++; if (cyc_a !== 32'(exp_cyc(0))) begin n_fail++; $display("FAIL alert_cycles got %0d want %0d", cyc_a, exp_cyc(0)); end
        rst = 1; tick(0); rst = 0;
        n_tests++; if (alert_a !== 1'b0) begin n_fail++; $display("FAIL alert_clear got %b want 0", alert_a); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_sleep_wake();
        test_wfi_with_wake();
        test_drain();
        test_saturation();
        test_reset_in_sleep();
        test_random();
        test_alert();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
